// File: rtl/ioff_scan_pkg.sv
// ----------------------------------------------------------------------------
// ioff_scan_pkg
// Shared definitions for the IO flip-flop scan-chain master.
//   - state encodings for the controller FSM (IDLE/CAPTURE/SHIFT/DONE)
//   - scan_state_t, also driven out of the top as a debug/observation port
// ----------------------------------------------------------------------------
package ioff_scan_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        CAPTURE = ST_CAPTURE,
        SHIFT   = ST_SHIFT,
        DONE    = ST_DONE
    } scan_state_t;

endpackage

// File: rtl/ioff_scan_shreg.sv
// ----------------------------------------------------------------------------
// ioff_scan_shreg
// WIDTH-bit load/shift register with serial input and serial output.
// Parallel load has priority over shift. Shifting moves bits towards the MSB;
// the MSB is the serial output.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears contents)
//   load, din  parallel load enable / data
//   shift, sin shift-left enable / serial input into bit 0
//   q          parallel contents
//   sout_next  value the MSB will hold after the coming clock edge, so a
//              registered serial output can be updated on the same edge
// ----------------------------------------------------------------------------
module ioff_scan_shreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout_next
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], sin};
        end
    end

    always_comb begin
        sout_next = q[WIDTH-1];
        if (load) begin
            sout_next = din[WIDTH-1];
        end else if (shift) begin
            sout_next = q[WIDTH-2];
        end
    end

endmodule

// File: rtl/ioff_scan_ctrl.sv
// ----------------------------------------------------------------------------
// ioff_scan_ctrl
// Master end of the IO flip-flop scan chain. Takes a CHAIN_LEN-bit pattern
// from the host, optionally performs one functional capture cycle (SE=0),
// then shifts the pattern into the chain for exactly CHAIN_LEN cycles while
// sampling the chain's serial output. The sampled word is returned to the
// host as the readback.
//
// Handshakes: a transfer happens on a rising CK edge where both valid and
// ready are high; valid/data are held by the source until that edge, and
// ready never depends combinationally on valid.
//
// Ports:
//   CK, global_reset   clock (chain cells share this edge), async reset high
//   wr_valid/wr_ready  host pattern handshake; wr_data MSB is shifted first
//   wr_data            pattern (MSB ends up in the last cell)
//   wr_capture         1: one functional capture cycle before shifting
//   rd_valid/rd_ready  readback handshake
//   rd_data            shifted-out bits, first SO sample in the MSB
//   busy               high in CAPTURE or SHIFT
//   scan_si/scan_se    to SI of first cell / SE of all cells
//   scan_so            from SO of last cell
//   fsm_state          current controller state, for observation
// ----------------------------------------------------------------------------
module ioff_scan_ctrl
    import ioff_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 32
) (
    input  logic                 CK,
    input  logic                 global_reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [CHAIN_LEN-1:0] wr_data,
    input  logic                 wr_capture,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [CHAIN_LEN-1:0] rd_data,
    output logic                 busy,
    output logic                 scan_si,
    output logic                 scan_se,
    input  logic                 scan_so,
    output scan_state_t          fsm_state
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    scan_state_t    state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    logic accept;
    logic rd_take;
    logic shifting;
    logic tx_si_next;

    logic wr_ready_d, rd_valid_d, busy_d, scan_se_d, scan_si_d;

    // tx parallel contents and rx look-ahead MSB are not needed here.
    logic [CHAIN_LEN-1:0] tx_par_unused;
    logic                 rx_msb_unused;

    assign accept   = (state == IDLE) && wr_valid && wr_ready;
    // rd_valid lags DONE entry by one cycle, so the handshake is qualified
    // by the registered rd_valid rather than by the state alone.
    assign rd_take  = (state == DONE) && rd_valid && rd_ready;
    assign shifting = (state == SHIFT);

    // Pattern register: loaded on accept, MSB feeds scan_si during SHIFT.
    ioff_scan_shreg #(.WIDTH(CHAIN_LEN)) u_tx (
        .clk       (CK),
        .rst       (global_reset),
        .load      (accept),
        .din       (wr_data),
        .shift     (shifting),
        .sin       (1'b0),
        .q         (tx_par_unused),
        .sout_next (tx_si_next)
    );

    // Readback register: scan_so sampled on the same edge the chain shifts,
    // so it collects the chain's pre-shift (or captured) contents.
    ioff_scan_shreg #(.WIDTH(CHAIN_LEN)) u_rx (
        .clk       (CK),
        .rst       (global_reset),
        .load      (1'b0),
        .din       ('0),
        .shift     (shifting),
        .sin       (scan_so),
        .q         (rd_data),
        .sout_next (rx_msb_unused)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = wr_capture ? CAPTURE : SHIFT;
                    cnt_d   = '0;
                end
            end
            CAPTURE: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt != CNT_W'(CHAIN_LEN)) begin
                    cnt_d = cnt + 1'b1;
                end
                // This edge takes sample number CHAIN_LEN.
                if (cnt == CNT_W'(CHAIN_LEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rd_take) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        wr_ready_d = (state_d == IDLE);
        rd_valid_d = (state == DONE) && !rd_take;
        busy_d     = (state_d == CAPTURE) || (state_d == SHIFT);
        scan_se_d  = (state_d == SHIFT);
        scan_si_d  = (state_d == SHIFT) && tx_si_next;
    end

    always_ff @(posedge CK or posedge global_reset) begin
        if (global_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            scan_se  <= 1'b0;
            scan_si  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            wr_ready <= wr_ready_d;
            rd_valid <= rd_valid_d;
            busy     <= busy_d;
            scan_se  <= scan_se_d;
            scan_si  <= scan_si_d;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_ioff_scan_ctrl.sv
`timescale 1ns/1ps
module tb_ioff_scan_ctrl;
    import ioff_scan_pkg::*;

    localparam int N = 32;
    localparam logic [N-1:0] DPAT  = {(N/2){2'b01}};  // D of cell i is 1 for even i
    localparam logic [1:0]   DPAT2 = 2'b01;

    // ---------------- clock / reset ----------------
    logic CK = 1'b0;
    logic global_reset = 1'b1;
    always #5 CK = ~CK;

    // ---------------- DUT (CHAIN_LEN = 32) ----------------
    logic         wr_valid = 1'b0, wr_capture = 1'b0, rd_ready = 1'b0;
    logic [N-1:0] wr_data = '0;
    logic         wr_ready, rd_valid, busy, scan_si, scan_se, scan_so;
    logic [N-1:0] rd_data;
    scan_state_t  fsm_state;

    ioff_scan_ctrl #(.CHAIN_LEN(N)) u_dut (
        .CK(CK), .global_reset(global_reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_capture(wr_capture),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .scan_si(scan_si), .scan_se(scan_se), .scan_so(scan_so),
        .fsm_state(fsm_state)
    );

    // ---------------- DUT (CHAIN_LEN = 2) ----------------
    logic       wr_valid2 = 1'b0, wr_capture2 = 1'b0, rd_ready2 = 1'b0;
    logic [1:0] wr_data2 = '0;
    logic       wr_ready2, rd_valid2, busy2, scan_si2, scan_se2, scan_so2;
    logic [1:0] rd_data2;
    scan_state_t fsm_state2;

    ioff_scan_ctrl #(.CHAIN_LEN(2)) u_dut2 (
        .CK(CK), .global_reset(global_reset),
        .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_data(wr_data2), .wr_capture(wr_capture2),
        .rd_valid(rd_valid2), .rd_ready(rd_ready2), .rd_data(rd_data2),
        .busy(busy2), .scan_si(scan_si2), .scan_se(scan_se2), .scan_so(scan_so2),
        .fsm_state(fsm_state2)
    );

    // ---------------- scan chain models ----------------
    // Cells shift when SE=1; they load D only during the functional capture
    // cycle (controller busy with SE low); otherwise they hold.
    logic [N-1:0] chain  = '0;
    logic [1:0]   chain2 = '0;
    always @(posedge CK) begin
        if (scan_se) chain <= {chain[N-2:0], scan_si};
        else if (busy) chain <= DPAT;
        if (scan_se2) chain2 <= {chain2[0], scan_si2};
        else if (busy2) chain2 <= DPAT2;
    end
    assign scan_so  = chain[N-1];
    assign scan_so2 = chain2[1];

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int fails   = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Timing is derived from the accept edge: busy for N(+1) cycles, scan_se
    // for exactly N cycles after any capture cycle, rd_valid from N+1(+1)
    // cycles after accept until the readback handshake.
    logic [N-1:0] exp_q[$];
    logic         chk_q[$];
    int           cyc = 0, t_acc = 0, mk = 0, mc = 0;
    logic         in_txn = 1'b0, m_cap = 1'b0, m_chain_ok = 1'b0;
    logic [N-1:0] m_pat = '0, m_chain = '0;
    logic         m_wr_ready = 1'b0, m_busy = 1'b0, m_se = 1'b0, m_si = 1'b0, m_rd_valid = 1'b0;

    always @(posedge CK or posedge global_reset) begin
        if (global_reset) begin
            in_txn = 1'b0; m_chain_ok = 1'b0;
            m_wr_ready = 1'b0; m_busy = 1'b0; m_se = 1'b0; m_si = 1'b0; m_rd_valid = 1'b0;
            exp_q.delete(); chk_q.delete();
        end else begin
            if (!in_txn && m_wr_ready && wr_valid) begin
                in_txn = 1'b1; t_acc = cyc; m_cap = wr_capture; m_pat = wr_data;
                exp_q.push_back(wr_capture ? DPAT : m_chain);
                chk_q.push_back(wr_capture || m_chain_ok);
                m_chain = wr_data; m_chain_ok = 1'b1;
            end else if (in_txn && m_rd_valid && rd_ready) begin
                in_txn = 1'b0;
                void'(exp_q.pop_front());
                void'(chk_q.pop_front());
            end
            m_wr_ready = !in_txn;
            m_busy = 1'b0; m_se = 1'b0; m_si = 1'b0; m_rd_valid = 1'b0;
            if (in_txn) begin
                mk = cyc - t_acc;
                mc = m_cap ? 1 : 0;
                m_busy     = (mk < N + mc);
                m_se       = (mk >= mc) && (mk < mc + N);
                m_rd_valid = (mk >= mc + N + 1);
                if (m_se) m_si = m_pat[N-1-(mk-mc)];
            end
            cyc++;
        end
    end

    // One compare process, every cycle, away from the active edge.
    always @(negedge CK) begin
        check("wr_ready", N'(wr_ready), N'(m_wr_ready));
        check("busy",     N'(busy),     N'(m_busy));
        check("scan_se",  N'(scan_se),  N'(m_se));
        check("scan_si",  N'(scan_si),  N'(m_si));
        check("rd_valid", N'(rd_valid), N'(m_rd_valid));
        if (global_reset) check("rd_data_reset", rd_data, '0);
        else if (m_rd_valid && chk_q.size() > 0 && chk_q[0]) check("rd_data", rd_data, exp_q[0]);
    end

    // ---------------- driver tasks ----------------
    int           lat, se_cnt, g, seen;
    logic [N-1:0] rd_word;

    // Offers a pattern at a negedge; after acceptance wr_valid stays high for
    // 'hold' more cycles with different data (must be ignored), then returns
    // once rd_valid is seen. lat = edges from accept to rd_valid.
    task automatic do_write(input logic [N-1:0] d, input logic cap, input int hold,
                            output int l, output int se);
        int gd;
        wr_data = d; wr_capture = cap; wr_valid = 1'b1;
        gd = 0;
        while (!wr_ready && gd < 100) begin @(negedge CK); gd++; end
        check("wr_accept_wait", N'(wr_ready), N'(1));
        @(negedge CK);
        wr_data = ~d; wr_capture = ~cap;
        l = 1; se = scan_se ? 1 : 0;
        for (int i = 0; i < hold; i++) begin @(negedge CK); l++; se += scan_se ? 1 : 0; end
        wr_valid = 1'b0;
        while (!rd_valid && l < 200) begin @(negedge CK); l++; se += scan_se ? 1 : 0; end
        check("rd_valid_wait", N'(rd_valid), N'(1));
        l = l - 1;
    endtask

    task automatic do_read(output logic [N-1:0] d);
        d = rd_data;
        rd_ready = 1'b1;
        @(negedge CK);
        rd_ready = 1'b0;
        check("rd_valid_after_take", N'(rd_valid), N'(0));
        check("wr_ready_after_take", N'(wr_ready), N'(1));
        check("state_after_take",    N'(fsm_state), N'(IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge CK);

        // 1: reset release
        global_reset = 1'b0;
        check("rst_scan_se",  N'(scan_se),  N'(0));
        check("rst_rd_valid", N'(rd_valid), N'(0));
        check("rst_wr_ready", N'(wr_ready), N'(0));
        @(negedge CK);
        check("rst_wr_ready_1cyc", N'(wr_ready), N'(1));
        check("rst_state", N'(fsm_state), N'(IDLE));

        // 2: two plain writes; second readback is the first pattern
        do_write(32'hA5A5_0F0F, 1'b0, 0, lat, se_cnt);
        do_read(rd_word);
        do_write(32'h1234_5678, 1'b0, 4, lat, se_cnt);
        check("lat_plain", N'(lat), N'(33));
        check("se_cycles_plain", N'(se_cnt), N'(32));
        do_read(rd_word);
        check("rd_plain", rd_word, 32'hA5A5_0F0F);

        // 3: capture write reads back the D pattern
        do_write(32'h0BAD_F00D, 1'b1, 2, lat, se_cnt);
        check("lat_capture", N'(lat), N'(34));
        check("se_cycles_capture", N'(se_cnt), N'(32));
        do_read(rd_word);
        check("rd_capture", rd_word, 32'h5555_5555);

        // 4: readback held in DONE, wr_valid pulses ignored
        do_write(32'hC3C3_3C3C, 1'b0, 0, lat, se_cnt);
        for (int i = 0; i < 10; i++) begin
            wr_valid = i[0]; wr_data = 32'hFFFF_FFFF; wr_capture = 1'b0;
            @(negedge CK);
            check("done_wr_ready", N'(wr_ready), N'(0));
            check("done_rd_valid", N'(rd_valid), N'(1));
            check("done_rd_data",  rd_data, 32'h0BAD_F00D);
        end
        wr_valid = 1'b0;
        do_read(rd_word);
        check("rd_held", rd_word, 32'h0BAD_F00D);
        @(negedge CK);
        check("idle_after_hold_busy", N'(busy), N'(0));

        // 5: reset at shift cycle 15
        wr_data = 32'h7777_1111; wr_capture = 1'b0; wr_valid = 1'b1;
        g = 0;
        while (!wr_ready && g < 100) begin @(negedge CK); g++; end
        @(negedge CK);
        wr_valid = 1'b0;
        seen = scan_se ? 1 : 0;
        g = 0;
        while (seen < 15 && g < 100) begin @(negedge CK); g++; seen += scan_se ? 1 : 0; end
        check("shift15_reached", N'(seen), N'(15));
        @(posedge CK);
        #2 global_reset = 1'b1;
        #1;
        check("async_rst_scan_se",  N'(scan_se),  N'(0));
        check("async_rst_busy",     N'(busy),     N'(0));
        check("async_rst_rd_valid", N'(rd_valid), N'(0));
        repeat (3) @(negedge CK);
        global_reset = 1'b0;
        @(negedge CK);
        check("rerst_wr_ready", N'(wr_ready), N'(1));
        do_write(32'h1357_9BDF, 1'b1, 0, lat, se_cnt);
        check("lat_after_rst", N'(lat), N'(34));
        do_read(rd_word);
        check("rd_after_rst_cap", rd_word, 32'h5555_5555);
        do_write(32'h2468_ACE0, 1'b0, 0, lat, se_cnt);
        do_read(rd_word);
        check("rd_after_rst_plain", rd_word, 32'h1357_9BDF);

        // 6: two-cell build: plain, plain, capture
        for (int rep = 0; rep < 3; rep++) begin
            wr_data2 = 2'b10; wr_capture2 = (rep == 2); wr_valid2 = 1'b1;
            g = 0;
            while (!wr_ready2 && g < 20) begin @(negedge CK); g++; end
            check("c2_accept_wait", N'(wr_ready2), N'(1));
            @(negedge CK);
            wr_valid2 = 1'b0;
            lat = 1;
            while (!rd_valid2 && lat < 20) begin @(negedge CK); lat++; end
            check("c2_rd_valid_wait", N'(rd_valid2), N'(1));
            if (rep == 1) begin
                check("c2_lat", N'(lat - 1), N'(3));
                check("c2_rd",  N'(rd_data2), N'(2'b10));
            end
            if (rep == 2) begin
                check("c2_lat_cap", N'(lat - 1), N'(4));
                check("c2_rd_cap",  N'(rd_data2), N'(DPAT2));
            end
            rd_ready2 = 1'b1;
            @(negedge CK);
            rd_ready2 = 1'b0;
            check("c2_rd_valid_drop", N'(rd_valid2), N'(0));
            check("c2_wr_ready_back", N'(wr_ready2), N'(1));
        end

        repeat (2) @(negedge CK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, fails);
        $fatal(1, "watchdog");
    end

endmodule
